// File: rtl/ysyx_22051013_cache_tag_ctrl_if.sv
// Signal bundle between the cache tag controller and its CPU, tag RAM and refill memory neighbours.
// The controller is the master: it owns the tag RAM port and the refill request.
interface ysyx_22051013_cache_tag_ctrl_if #(
    parameter int TAG_W = 24,
    parameter int IDX_W = 5,
    parameter int OFF_W = 3
);
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    logic              cpu_req_valid;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_req_ready;
    logic              cpu_resp_valid;
    logic              cpu_resp_hit;

    logic              inv_all;
    logic              inv_busy;

    logic [IDX_W-1:0]  tag_addr;
    logic              tag_we;
    logic [TAG_W:0]    tag_wdata;
    logic [TAG_W-1:0]  tag_rdata;
    logic              tag_rvalid;

    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;

    modport master (
        input  cpu_req_valid, cpu_req_addr, inv_all,
        input  tag_rdata, tag_rvalid,
        input  mem_req_ready, mem_resp_valid,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, inv_busy,
        output tag_addr, tag_we, tag_wdata,
        output mem_req_valid, mem_req_addr
    );

    modport slave (
        output cpu_req_valid, cpu_req_addr, inv_all,
        output tag_rdata, tag_rvalid,
        output mem_req_ready, mem_resp_valid,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, inv_busy,
        input  tag_addr, tag_we, tag_wdata,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ysyx_22051013_cache_tag_ctrl.sv
// Lookup/refill controller for a direct-mapped cache tag store, with a full-store
// invalidate sweep after reset and on fence.
module ysyx_22051013_cache_tag_ctrl #(
    parameter int TAG_W = 24,
    parameter int IDX_W = 5,
    parameter int OFF_W = 3
) (
    input logic clk,
    input logic rst_n,
    ysyx_22051013_cache_tag_ctrl_if.master bus
);
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
    localparam int LINE_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        S_INVAL,
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_UPDATE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              hit_q, hit_d;
    logic              inv_pend_q, inv_pend_d;

    logic [TAG_W-1:0]  line_tag;
    logic [IDX_W-1:0]  line_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              tag_match;
    logic              last_set;
    logic              busy_lookup;
    logic              unused_off;

    assign line_tag    = line_q[LINE_W-1:IDX_W];
    assign line_idx    = line_q[IDX_W-1:0];
    assign req_idx     = bus.cpu_req_addr[OFF_W +: IDX_W];
    assign tag_match   = bus.tag_rvalid && (bus.tag_rdata == line_tag);
    assign last_set    = (cnt_q == {IDX_W{1'b1}});
    assign busy_lookup = (state_q == S_LOOKUP) || (state_q == S_MISS_REQ) ||
                         (state_q == S_MISS_WAIT) || (state_q == S_UPDATE);
    // Byte offset within the line plays no part in tag lookup.
    assign unused_off  = ^bus.cpu_req_addr[OFF_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INVAL;
            cnt_q      <= '0;
            line_q     <= '0;
            hit_q      <= 1'b0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            hit_q      <= hit_d;
            inv_pend_q <= inv_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        hit_d      = hit_q;
        inv_pend_d = inv_pend_q;

        unique case (state_q)
            S_INVAL: begin
                cnt_d = cnt_q + 1'b1;
                if (last_set) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // A fence wins over a same-cycle lookup; the CPU retries after the sweep.
                if (bus.inv_all) begin
                    state_d = S_INVAL;
                    cnt_d   = '0;
                end else if (bus.cpu_req_valid) begin
                    line_d  = bus.cpu_req_addr[ADDR_W-1:OFF_W];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d   = tag_match;
                state_d = tag_match ? S_RESP : S_MISS_REQ;
            end
            S_MISS_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (inv_pend_q || bus.inv_all) begin
                    state_d    = S_INVAL;
                    cnt_d      = '0;
                    inv_pend_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INVAL;
                cnt_d   = '0;
            end
        endcase

        // A fence arriving mid-transaction is deferred until the response has gone out.
        if (bus.inv_all && busy_lookup) begin
            inv_pend_d = 1'b1;
        end
    end

    always_comb begin
        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_resp_hit   = 1'b0;
        bus.inv_busy       = 1'b0;
        bus.tag_addr       = '0;
        bus.tag_we         = 1'b0;
        bus.tag_wdata      = '0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_addr   = '0;

        // Outputs are forced low while reset is held, even though the state sits in INVAL.
        if (rst_n) begin
            bus.tag_addr = line_idx;
            unique case (state_q)
                S_INVAL: begin
                    bus.tag_addr = cnt_q;
                    bus.tag_we   = 1'b1;
                    bus.inv_busy = 1'b1;
                end
                S_IDLE: begin
                    bus.cpu_req_ready = !inv_pend_q;
                    bus.tag_addr      = req_idx;
                end
                S_MISS_REQ: begin
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_addr  = {line_q, {OFF_W{1'b0}}};
                end
                S_UPDATE: begin
                    bus.tag_we    = 1'b1;
                    bus.tag_wdata = {1'b1, line_tag};
                end
                S_RESP: begin
                    bus.cpu_resp_valid = 1'b1;
                    bus.cpu_resp_hit   = hit_q;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
